median3x3_win_ctrl: RTL

Window scheduler and sequencer for the 3x3 median sorter in the low-light enhancement pipeline. It accepts one raster-order 8-bit pixel stream per frame, buffers two lines, and forms the 3x3 neighbourhood for every pixel. It drives the nine sorter inputs and tracks the sorter's fixed latency so each returned median is tagged valid and frame-last. It also flushes the final row and column so exactly IMG_W*IMG_H medians leave per frame.

---
 rtl/median3x3_win_ctrl_if.sv | 27 ++
 rtl/median3x3_win_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/median3x3_win_ctrl_if.sv
// Pixel stream, sorter window/median and status signals of the 3x3 median window controller.
// Names carry the controller's view: i_* are driven into it, o_* are driven by it.
interface median3x3_win_ctrl_if;
  logic       i_start;
  logic [7:0] i_pix_in;
  logic       i_pix_valid;
  logic       o_pix_ready;
  logic [7:0] o_win1, o_win2, o_win3, o_win4, o_win5, o_win6, o_win7, o_win8, o_win9;
  logic [7:0] i_med_in;
  logic [7:0] o_pix_out;
  logic       o_out_valid;
  logic       o_out_last;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_start, i_pix_in, i_pix_valid, i_med_in,
    output o_pix_ready, o_win1, o_win2, o_win3, o_win4, o_win5, o_win6, o_win7, o_win8, o_win9,
    output o_pix_out, o_out_valid, o_out_last, o_busy, o_done
  );

  modport master (
    output i_start, i_pix_in, i_pix_valid, i_med_in,
    input  o_pix_ready, o_win1, o_win2, o_win3, o_win4, o_win5, o_win6, o_win7, o_win8, o_win9,
    input  o_pix_out, o_out_valid, o_out_last, o_busy, o_done
  );
endinterface

// File: rtl/median3x3_win_ctrl.sv
// 3x3 window scheduler for a fixed-latency median sorter: two line buffers, zero-padded borders,
// end-of-frame flush. Optional macro MEDIAN_BORDER_BYPASS_EN passes border centres through unsorted.
module median3x3_win_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int SORT_LAT = 2
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  median3x3_win_ctrl_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 2);
  localparam int DW = $clog2(SORT_LAT + 1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_FLUSH = YW'(IMG_H + 1);
  localparam logic [DW-1:0] D_LAST  = DW'(SORT_LAT);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic [XW-1:0]          r_x_in, r_x_o;
  logic [YW-1:0]          r_y_in, r_y_o;
  logic [DW-1:0]          r_drain;
  logic [7:0]             r_lb0 [IMG_W];
  logic [7:0]             r_lb1 [IMG_W];
  logic [2:0][7:0]        r_cm, r_cr;
  logic [8:0][7:0]        r_win;
  logic [SORT_LAT:0]      r_vld_pipe, r_last_pipe;

  logic                   w_push, w_emit, w_last;
  logic [7:0]             w_pix, w_med;
  logic [2:0][7:0]        w_newcol;
  logic [8:0][7:0]        w_win;

  assign w_push   = ((r_state == S_FILL || r_state == S_RUN) && bus.i_pix_valid) || r_state == S_FLUSH;
  assign w_emit   = (r_state == S_RUN && bus.i_pix_valid) || r_state == S_FLUSH;
  assign w_pix    = (r_state == S_FLUSH) ? 8'd0 : bus.i_pix_in;
  // Column entering the window: [0] two lines up, [1] one line up, [2] the new pixel.
  assign w_newcol = {w_pix, r_lb1[r_x_in], r_lb0[r_x_in]};
  assign w_last   = (r_x_o == X_LAST) && (r_y_o == Y_LAST);

  // Centre is (r_x_o, r_y_o); anything outside the image, including the wrapped column, reads 0.
  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      w_win[3*r]   = (r_x_o == '0)     ? 8'd0 : r_cm[r];
      w_win[3*r+1] = r_cr[r];
      w_win[3*r+2] = (r_x_o == X_LAST) ? 8'd0 : w_newcol[r];
    end
    if (r_y_o == '0) begin
      w_win[0] = 8'd0; w_win[1] = 8'd0; w_win[2] = 8'd0;
    end
    if (r_y_o == Y_LAST) begin
      w_win[6] = 8'd0; w_win[7] = 8'd0; w_win[8] = 8'd0;
    end
  end

  // Line buffers hold no reset: stale rows are only ever read for the masked row -1.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_lb0[r_x_in] <= r_lb1[r_x_in];
      r_lb1[r_x_in] <= w_pix;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_x_in      <= '0;
      r_y_in      <= '0;
      r_x_o       <= '0;
      r_y_o       <= '0;
      r_drain     <= '0;
      r_cm        <= '0;
      r_cr        <= '0;
      r_win       <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[SORT_LAT-1:0], w_emit};
      r_last_pipe <= {r_last_pipe[SORT_LAT-1:0], w_emit & w_last};
      if (w_push) begin
        r_cm <= r_cr;
        r_cr <= w_newcol;
        if (r_x_in == X_LAST) begin
          r_x_in <= '0;
          r_y_in <= r_y_in + 1'b1;
        end else begin
          r_x_in <= r_x_in + 1'b1;
        end
      end
      if (w_emit) begin
        r_win <= w_win;
        if (r_x_o == X_LAST) begin
          r_x_o <= '0;
          r_y_o <= r_y_o + 1'b1;
        end else begin
          r_x_o <= r_x_o + 1'b1;
        end
      end
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_state <= S_FILL;
          r_x_in  <= '0;
          r_y_in  <= '0;
          r_x_o   <= '0;
          r_y_o   <= '0;
        end
        S_FILL:  if (w_push && r_x_in == '0 && r_y_in == Y_ONE) r_state <= S_RUN;
        S_RUN:   if (w_push && r_x_in == X_LAST && r_y_in == Y_LAST) r_state <= S_FLUSH;
        S_FLUSH: if (r_y_in == Y_FLUSH) begin
          r_state <= S_DRAIN;
          r_drain <= '0;
        end
        // One extra cycle over SORT_LAT covers the win register, so done follows out_last.
        S_DRAIN: if (r_drain == D_LAST) r_state <= S_DONE;
                 else r_drain <= r_drain + 1'b1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEDIAN_BORDER_BYPASS_EN
  logic [SORT_LAT:0]      r_bord_pipe;
  logic [SORT_LAT:0][7:0] r_ctr_pipe;
  logic                   w_border;

  assign w_border = (r_x_o == '0) || (r_x_o == X_LAST) || (r_y_o == '0) || (r_y_o == Y_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bord_pipe <= '0;
      r_ctr_pipe  <= '0;
    end else begin
      r_bord_pipe <= {r_bord_pipe[SORT_LAT-1:0], w_emit & w_border};
      r_ctr_pipe  <= {r_ctr_pipe[SORT_LAT-1:0], r_cr[1]};
    end
  end

  assign w_med = r_bord_pipe[SORT_LAT] ? r_ctr_pipe[SORT_LAT] : bus.i_med_in;
`else
  assign w_med = bus.i_med_in;
`endif

  assign bus.o_pix_ready = (r_state == S_FILL) || (r_state == S_RUN);
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_out_valid = r_vld_pipe[SORT_LAT];
  assign bus.o_out_last  = r_last_pipe[SORT_LAT];
  assign bus.o_pix_out   = r_vld_pipe[SORT_LAT] ? w_med : 8'd0;
  assign bus.o_win1 = r_win[0];
  assign bus.o_win2 = r_win[1];
  assign bus.o_win3 = r_win[2];
  assign bus.o_win4 = r_win[3];
  assign bus.o_win5 = r_win[4];
  assign bus.o_win6 = r_win[5];
  assign bus.o_win7 = r_win[6];
  assign bus.o_win8 = r_win[7];
  assign bus.o_win9 = r_win[8];
endmodule
